// File: rtl/kuznechik_pkg.sv
// kuznechik_pkg
// Shared definitions for the Kuznechik key path: default round-key geometry,
// round-key and round-key-pair types, and the state encodings of the
// round-key store's write and read FSMs.
package kuznechik_pkg;

    localparam int KEY_W_DEF  = 128;
    localparam int NUM_RK_DEF = 10;

    typedef logic [KEY_W_DEF-1:0] rk_t;

    // Pair as emitted by keygen: odd key K(2i+1) in the upper half.
    typedef struct packed {
        rk_t odd;
        rk_t even;
    } rk_pair_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_LOAD = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } r_state_t;

endpackage

// File: rtl/kuznechik_rk_store_if.sv
// kuznechik_rk_store_if
// Round-key stream bus from the key store to the cipher core.
//   rk_valid : rk_data/rk_last are valid
//   rk_ready : consumer accepts the current beat
//   rk_data  : current round key
//   rk_last  : final beat of the stream
// master = key store (source), slave = cipher core (sink).
interface kuznechik_rk_store_if #(parameter int KEY_W = 128);
    logic             rk_valid;
    logic             rk_ready;
    logic [KEY_W-1:0] rk_data;
    logic             rk_last;

    modport master (output rk_valid, output rk_data, output rk_last, input rk_ready);
    modport slave  (input rk_valid, input rk_data, input rk_last, output rk_ready);
endinterface

// File: rtl/kuznechik_rk_stream.sv
// kuznechik_rk_stream
// Read side of the round-key store: read FSM, key index counter and the
// registered output beat, over a read-only view of the key storage.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr                 synchronous abort to idle (zeroize)
//   rd_req/slot/dir     stream request; dir 0 = K1..Kn, 1 = Kn..K1
//   slot_valid, store   read-only view of the store
//   rd_busy, rd_err     stream in progress / rejected request pulse
//   act, act_slot       slot that is streaming or being accepted this cycle
//   rk_valid/ready/data/last  output stream
module kuznechik_rk_stream
    import kuznechik_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int KEY_W     = 128,
    parameter int NUM_RK    = 10,
    parameter int SW        = 1,
    parameter int IW        = 4
)(
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      clr,
    input  logic                                      rd_req,
    input  logic [SW-1:0]                             rd_slot,
    input  logic                                      rd_dir,
    input  logic [NUM_SLOTS-1:0]                      slot_valid,
    input  logic [NUM_SLOTS-1:0][NUM_RK-1:0][KEY_W-1:0] store,
    output logic                                      rd_busy,
    output logic                                      rd_err,
    output logic                                      act,
    output logic [SW-1:0]                             act_slot,
    output logic                                      rk_valid,
    input  logic                                      rk_ready,
    output logic [KEY_W-1:0]                          rk_data,
    output logic                                      rk_last
);

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_RK - 1);

    r_state_t      r_st, r_nxt;
    logic [SW-1:0] slot_q, ld_slot;
    logic          dir_q, ld_dir;
    logic [IW-1:0] idx, ld_idx;
    logic          ld_last, slot_ok, hs, accept, reject;

    assign rk_valid = (r_st == R_STREAM);
    assign rd_busy  = (r_st == R_STREAM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st <= R_IDLE;
        else        r_st <= r_nxt;
    end

    always_comb begin
        slot_ok = (32'(rd_slot) < NUM_SLOTS) && slot_valid[rd_slot];
        hs      = (r_st == R_STREAM) && rk_ready;
        r_nxt   = r_st;
        accept  = 1'b0;
        reject  = 1'b0;
        case (r_st)
            R_IDLE: begin
                if (rd_req) begin
                    if (slot_ok) begin
                        accept = 1'b1;
                        r_nxt  = R_STREAM;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            R_STREAM: if (hs && rk_last) r_nxt = R_IDLE;
            default:  r_nxt = R_IDLE;
        endcase
        if (clr) begin
            r_nxt  = R_IDLE;
            accept = 1'b0;
            reject = 1'b0;
        end
        // Next beat: either the first key of a new stream or the neighbour
        // of the key just handed over.
        ld_slot = accept ? rd_slot : slot_q;
        ld_dir  = accept ? rd_dir  : dir_q;
        if (accept) ld_idx = rd_dir ? IDX_LAST : '0;
        else        ld_idx = dir_q ? idx - IW'(1) : idx + IW'(1);
        ld_last = ld_dir ? (ld_idx == '0) : (ld_idx == IDX_LAST);
        // The accepting cycle counts as streaming so a same-cycle load of
        // that slot is rejected by the writer.
        act      = (r_st == R_STREAM) || accept;
        act_slot = (r_st == R_STREAM) ? slot_q : rd_slot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            dir_q   <= 1'b0;
            idx     <= '0;
            rk_data <= '0;
            rk_last <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            rd_err <= reject;
            if (clr) begin
                rk_data <= '0;
                rk_last <= 1'b0;
            end else if (accept || (hs && !rk_last)) begin
                slot_q  <= ld_slot;
                dir_q   <= ld_dir;
                idx     <= ld_idx;
                rk_data <= store[ld_slot][ld_idx];
                rk_last <= ld_last;
            end else if (hs) begin
                rk_data <= '0;
                rk_last <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/kuznechik_rk_store.sv
// kuznechik_rk_store
// Multi-slot round-key store between keygen and the cipher datapath.
// Captures keygen round-key pairs into one of NUM_SLOTS contexts and streams
// a complete context one key per beat, forward (encrypt) or reverse (decrypt).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   zeroize               (only with KUZ_RK_ZEROIZE_EN) wipe keys, abort FSMs
//   wr_start, wr_slot     begin loading a context
//   pair_valid, pair_data keygen pair; upper half K(2i+1), lower half K(2i+2)
//   wr_done, wr_err       load complete / load rejected pulses
//   slot_valid            per-slot "context complete"
//   rd_req/slot/dir       stream request; rd_busy, rd_err status
//   rk                    round-key stream (master modport)
// Optional build macro: KUZ_RK_ZEROIZE_EN adds the zeroize input.
module kuznechik_rk_store
    import kuznechik_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int KEY_W     = KEY_W_DEF,
    parameter int NUM_RK    = NUM_RK_DEF,
    localparam int SW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
)(
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef KUZ_RK_ZEROIZE_EN
    input  logic                   zeroize,
`endif
    input  logic                   wr_start,
    input  logic [SW-1:0]          wr_slot,
    input  logic                   pair_valid,
    input  logic [2*KEY_W-1:0]     pair_data,
    output logic                   wr_done,
    output logic                   wr_err,
    output logic [NUM_SLOTS-1:0]   slot_valid,
    input  logic                   rd_req,
    input  logic [SW-1:0]          rd_slot,
    input  logic                   rd_dir,
    output logic                   rd_busy,
    output logic                   rd_err,
    kuznechik_rk_store_if.master   rk
);

    localparam int IW = $clog2(NUM_RK);
    localparam int NP = NUM_RK / 2;
    localparam int CW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NP - 1);

    if (NUM_RK % 2 != 0 || NUM_RK < 2) begin : g_rk_even_chk
        $fatal(1, "kuznechik_rk_store: NUM_RK must be even and >= 2");
    end

    logic clr;
`ifdef KUZ_RK_ZEROIZE_EN
    assign clr = zeroize;
`else
    assign clr = 1'b0;
`endif

    logic [NUM_SLOTS-1:0][NUM_RK-1:0][KEY_W-1:0] store;
    w_state_t      w_st, w_nxt;
    logic [SW-1:0] wslot, act_slot;
    logic [CW-1:0] cnt;
    logic [IW-1:0] k_odd, k_even;
    logic          act, start_ok, start_rej, pair_we, done;

    // Pair cnt lands in key indices 2*cnt (odd key) and 2*cnt+1.
    assign k_odd  = IW'({cnt, 1'b0});
    assign k_even = k_odd | IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_st <= W_IDLE;
        else        w_st <= w_nxt;
    end

    always_comb begin
        w_nxt     = w_st;
        start_ok  = 1'b0;
        start_rej = 1'b0;
        pair_we   = 1'b0;
        done      = 1'b0;
        // wr_start beats a same-cycle pair; a rejected restart in W_LOAD
        // keeps the current load going but still drops that pair.
        if (wr_start) begin
            if ((32'(wr_slot) >= NUM_SLOTS) || (act && act_slot == wr_slot)) begin
                start_rej = 1'b1;
            end else begin
                start_ok = 1'b1;
                w_nxt    = W_LOAD;
            end
        end else if (w_st == W_LOAD && pair_valid) begin
            pair_we = 1'b1;
            if (cnt == CNT_LAST) begin
                done  = 1'b1;
                w_nxt = W_IDLE;
            end
        end
        if (clr) begin
            w_nxt     = W_IDLE;
            start_ok  = 1'b0;
            start_rej = 1'b0;
            pair_we   = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store      <= '0;
            slot_valid <= '0;
            wslot      <= '0;
            cnt        <= '0;
            wr_done    <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            wr_done <= done;
            wr_err  <= start_rej;
            if (clr) begin
                store      <= '0;
                slot_valid <= '0;
                cnt        <= '0;
            end else begin
                if (start_ok) begin
                    slot_valid[wr_slot] <= 1'b0;
                    wslot               <= wr_slot;
                    cnt                 <= '0;
                end
                if (pair_we) begin
                    store[wslot][k_odd]  <= pair_data[2*KEY_W-1:KEY_W];
                    store[wslot][k_even] <= pair_data[KEY_W-1:0];
                    cnt                  <= cnt + CW'(1);
                end
                if (done) slot_valid[wslot] <= 1'b1;
            end
        end
    end

    kuznechik_rk_stream #(
        .NUM_SLOTS (NUM_SLOTS),
        .KEY_W     (KEY_W),
        .NUM_RK    (NUM_RK),
        .SW        (SW),
        .IW        (IW)
    ) u_stream (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .rd_req     (rd_req),
        .rd_slot    (rd_slot),
        .rd_dir     (rd_dir),
        .slot_valid (slot_valid),
        .store      (store),
        .rd_busy    (rd_busy),
        .rd_err     (rd_err),
        .act        (act),
        .act_slot   (act_slot),
        .rk_valid   (rk.rk_valid),
        .rk_ready   (rk.rk_ready),
        .rk_data    (rk.rk_data),
        .rk_last    (rk.rk_last)
    );

endmodule

// File: doc/kuznechik_rk_store.md
Name: kuznechik_rk_store

Overview:
- Multi-slot round-key store between kuznechik_keygen and the encrypt/decrypt datapath.
- Captures the 2×128-bit round-key pairs emitted by keygen into one of NUM_SLOTS key contexts.
- Streams a stored context to the cipher core one 128-bit key per beat, with valid/ready.
- Streams in forward order (K1..K10, encrypt) or reverse order (K10..K1, decrypt), so the core no longer needs the key serialised at generation time.

Parameters:
- NUM_SLOTS, 2, number of independent key contexts (≥1).
- KEY_W, 128, round-key width in bits.
- NUM_RK, 10, round keys per context; must be even, checked at elaboration (fatal otherwise).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_start  in  1  begin loading context wr_slot.
- wr_slot  in  SW=max(1,$clog2(NUM_SLOTS))  target slot for a load.
- pair_valid  in  1  keygen pair strobe (keygen ready).
- pair_data  in  2*KEY_W  [2*KEY_W-1:KEY_W] is the odd key K(2i+1); [KEY_W-1:0] is K(2i+2).
- wr_done  out  1  one-cycle pulse when the final pair is stored.
- wr_err  out  1  one-cycle pulse when wr_start is rejected.
- slot_valid  out  NUM_SLOTS  bit s set means context s is complete.
- rd_req  in  1  request a stream.
- rd_slot  in  SW  slot to stream.
- rd_dir  in  1  0 = forward K1..K10; 1 = reverse K10..K1.
- rd_busy  out  1  stream in progress.
- rd_err  out  1  one-cycle pulse when rd_req is rejected.
- rk_valid  out  1  rk_data is valid.
- rk_ready  in  1  consumer accepts the beat.
- rk_data  out  KEY_W  current round key.
- rk_last  out  1  final beat of the stream.

Behaviour:
- Reset: all outputs 0; slot_valid all 0; storage cleared to 0; both FSMs idle.
- Write FSM, states W_IDLE and W_LOAD:
  - W_IDLE + wr_start: if wr_slot is the slot currently streaming, or wr_slot ≥ NUM_SLOTS, pulse wr_err and stay in W_IDLE.
  - Otherwise clear slot_valid[wr_slot], clear the pair counter, go to W_LOAD.
  - W_LOAD + pair_valid: write pair_data into keys 2*cnt and 2*cnt+1 of the slot, then cnt++.
  - On pair NUM_RK/2: set slot_valid, pulse wr_done in the same cycle slot_valid rises, return to W_IDLE.
  - pair_valid in W_IDLE is ignored.
  - wr_start in W_LOAD restarts on the new slot, subject to the same rejection rule. The abandoned slot stays invalid.
  - If wr_start and pair_valid occur in the same cycle, wr_start wins and the pair is dropped.
- Read FSM, states R_IDLE and R_STREAM:
  - R_IDLE + rd_req: if slot_valid[rd_slot]=0 or rd_slot is out of range, pulse rd_err.
  - Otherwise latch slot and dir, set the index to 0 (fwd) or NUM_RK-1 (rev), go to R_STREAM.
  - rk_valid and rd_busy rise the cycle after acceptance (latency 1).
  - rk_data is registered. It holds stable while rk_valid && !rk_ready; the next key loads on handshake.
  - rk_last is high with the final key. The handshake on that key returns the FSM to R_IDLE next cycle, with rk_valid=0 for at least one cycle.
  - rd_req while rd_busy is ignored (no rd_err).
- Reads of the slot currently being loaded fail via slot_valid=0. Load and stream of different slots run concurrently.
- The stream always uses the slot contents latched at acceptance. A write to that slot is prevented by the wr_err rule.

Optional Feature:
- Macro: KUZ_RK_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - A one-cycle assertion clears all storage and slot_valid, and aborts both FSMs to idle.
  - rk_valid, rk_last and rd_busy drop the next cycle; no wr_done or errors are produced.
  - zeroize has priority over every other input in the same cycle.
- Undefined: port absent; keys are cleared only by reset.

Decomposition:
- Shared package kuznechik_pkg:
  - KEY_W and NUM_RK defaults.
  - Typedef rk_t (logic [KEY_W-1:0]).
  - Typedef rk_pair_t.
  - Enums for the write and read FSM states.
- One natural sub-module, kuznechik_rk_stream: read FSM, index counter and output register over a read-only view of the store. The write FSM and storage stay in the top.

Test Plan:
- Load slot 0 with pairs {A1,A2}..{A9,AA} (128-bit patterns), then rd_req fwd with rk_ready=1 → wr_done once after pair 5; rk_data A1..AA on 10 consecutive cycles starting 1 cycle after rd_req; rk_last on AA.
- Same slot, rd_dir=1, rk_ready toggling 1,0,1,0 → order AA..A1; data held stable during stalls; exactly 10 handshakes.
- rd_req on empty slot 1 → rd_err pulse, rk_valid stays 0. wr_start to slot 0 during its stream → wr_err; slot 0 contents unchanged.
- Stream slot 0 while loading slot 1 with B-keys → both complete; slot_valid=2'b11; a slot 1 read returns B1..BA.
- wr_start on slot 1 after 2 pairs, then wr_start on slot 0 → slot_valid[1]=0; slot 0 reload holds only the new pairs.
- Reset asserted mid-stream (and zeroize with KUZ_RK_ZEROIZE_EN) → outputs 0 immediately or next cycle; slot_valid=0; a subsequent read gives rd_err.
